// File: rtl/chan_mux_rr.sv
// chan_mux_rr
//   Registered N-channel, W-bit multiplexer with per-channel valid/ready.
//   It replaces the old externally selected 4:1 mux. Internal arbitration
//   chooses one requesting channel per cycle, by fixed priority or
//   round-robin. The chosen word goes into a single output register that
//   feeds one shared consumer.
//
// Parameters
//   NUM_CH : number of input channels (2..16)
//   WIDTH  : data width per channel
//   SEL_W  : channel index width, 2**SEL_W >= NUM_CH
//   MODE   : 0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports
//   clk       : rising-edge clock
//   reset_n   : synchronous active-low reset
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel request
//   in_ready  : per-channel accept (combinational, at most one bit set)
//   out_data  : registered selected data
//   out_valid : registered output valid
//   out_ready : consumer accept
//   out_ch    : registered index of the channel held in out_data
//   force_en  : (CHAN_MUX_FORCE_SEL_EN only) restrict grant to force_sel
//   force_sel : (CHAN_MUX_FORCE_SEL_EN only) the only eligible channel
//
// Optional feature macro: CHAN_MUX_FORCE_SEL_EN

module chan_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 2,
  parameter int MODE   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef CHAN_MUX_FORCE_SEL_EN
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
`endif
  output logic [SEL_W-1:0]        out_ch
);

  logic [SEL_W-1:0]  last_ptr;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic              load;

  // The output register can take a new word when it is empty or is being
  // drained on this same edge.
  assign load = !out_valid || out_ready;

  // A forced select narrows the candidates to a single channel. An index at
  // or above NUM_CH matches nothing, so no grant is made.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef CHAN_MUX_FORCE_SEL_EN
      eligible[i] = in_valid[i] && (!force_en || (force_sel == SEL_W'(i)));
`else
      eligible[i] = in_valid[i];
`endif
    end
  end

  // Round-robin works in two passes. The first pass looks only at indices
  // above last_ptr. If that finds nothing, the second pass takes the lowest
  // eligible index, which gives the wrap-around. Fixed priority uses only
  // the second pass.
  always_comb begin
    grant      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    if (MODE == 1) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant_any && eligible[i] && (SEL_W'(i) > last_ptr)) begin
          grant_any  = 1'b1;
          grant_idx  = SEL_W'(i);
          grant[i]   = 1'b1;
          grant_data = in_data[i*WIDTH +: WIDTH];
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_any && eligible[i]) begin
        grant_any  = 1'b1;
        grant_idx  = SEL_W'(i);
        grant[i]   = 1'b1;
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = grant & {NUM_CH{load && reset_n}};

  // When a grant is accepted, the new word overwrites the register, which
  // covers simultaneous drain and refill. Without an accept, a drained word
  // only clears valid, so out_data and out_ch keep their old values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_ptr  <= SEL_W'(NUM_CH - 1);
    end else begin
      if (grant_any && load) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        if (MODE == 1) begin
          last_ptr <= grant_idx;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_rr.sv
// tb_chan_mux_rr
//   Directed bench for chan_mux_rr. It drives two instances from one clock.
//   The first is round-robin, with SEL_W=3 so that a forced index of 5 can
//   be expressed. The second is fixed priority. Each expected value below
//   was worked out by hand from the arbitration rules.

module tb_chan_mux_rr;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [31:0] rr_in_data;
  logic [3:0]  rr_in_valid;
  logic [3:0]  rr_in_ready;
  logic [7:0]  rr_out_data;
  logic        rr_out_valid;
  logic        rr_out_ready;
  logic [2:0]  rr_out_ch;
  logic        rr_force_en;
  logic [2:0]  rr_force_sel;

  logic [31:0] fp_in_data;
  logic [3:0]  fp_in_valid;
  logic [3:0]  fp_in_ready;
  logic [7:0]  fp_out_data;
  logic        fp_out_valid;
  logic        fp_out_ready;
  logic [1:0]  fp_out_ch;
  logic        fp_force_en;
  logic [1:0]  fp_force_sel;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chan_mux_rr #(.NUM_CH(4), .WIDTH(8), .SEL_W(3), .MODE(1)) dut_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (rr_in_data),
    .in_valid  (rr_in_valid),
    .in_ready  (rr_in_ready),
    .out_data  (rr_out_data),
    .out_valid (rr_out_valid),
    .out_ready (rr_out_ready),
`ifdef CHAN_MUX_FORCE_SEL_EN
    .force_en  (rr_force_en),
    .force_sel (rr_force_sel),
`endif
    .out_ch    (rr_out_ch)
  );

  chan_mux_rr #(.NUM_CH(4), .WIDTH(8), .SEL_W(2), .MODE(0)) dut_fp (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (fp_in_data),
    .in_valid  (fp_in_valid),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_valid (fp_out_valid),
    .out_ready (fp_out_ready),
`ifdef CHAN_MUX_FORCE_SEL_EN
    .force_en  (fp_force_en),
    .force_sel (fp_force_sel),
`endif
    .out_ch    (fp_out_ch)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic ready);
    rr_in_valid  = valid;
    rr_in_data   = data;
    rr_out_ready = ready;
    #1;
  endtask

  // Step to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRr(input string tag, input logic v, input logic [7:0] d, input logic [2:0] ch);
    checkOutput({tag, "_valid"}, {31'd0, rr_out_valid}, {31'd0, v});
    checkOutput({tag, "_data"},  {24'd0, rr_out_data},  {24'd0, d});
    checkOutput({tag, "_ch"},    {29'd0, rr_out_ch},    {29'd0, ch});
  endtask

  initial begin
    reset_n      = 1'b0;
    rr_force_en  = 1'b0;
    rr_force_sel = 3'd0;
    fp_force_en  = 1'b0;
    fp_force_sel = 2'd0;
    fp_in_data   = 32'h0;
    fp_in_valid  = 4'b0000;
    fp_out_ready = 1'b1;

    // Reset held for two edges with every channel requesting.
    applyStimulus(4'b1111, 32'hA3A2A1A0, 1'b1);
    checkOutput("reset_in_ready", {28'd0, rr_in_ready}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkRr("reset", 1'b0, 8'h00, 3'd0);
      checkOutput("reset_in_ready_held", {28'd0, rr_in_ready}, 32'h0);
      checkOutput("reset_fp_valid", {31'd0, fp_out_valid}, 32'h0);
    end

    // Round-robin fairness: the pointer starts at 3, so channel 0 goes first.
    reset_n = 1'b1;
    #1;
    checkOutput("rr_first_ready", {28'd0, rr_in_ready}, 32'h1);
    tick(); checkRr("rr0", 1'b1, 8'hA0, 3'd0);
    checkOutput("rr_ready_ch1", {28'd0, rr_in_ready}, 32'h2);
    tick(); checkRr("rr1", 1'b1, 8'hA1, 3'd1);
    tick(); checkRr("rr2", 1'b1, 8'hA2, 3'd2);
    tick(); checkRr("rr3", 1'b1, 8'hA3, 3'd3);
    tick(); checkRr("rr_wrap", 1'b1, 8'hA0, 3'd0);

    // Drain the register, then load 0x55 from channel 1.
    applyStimulus(4'b0000, 32'hA3A2A1A0, 1'b1);
    tick(); checkOutput("empty_valid", {31'd0, rr_out_valid}, 32'h0);
    applyStimulus(4'b0010, 32'h00005500, 1'b1);
    tick(); checkRr("load55", 1'b1, 8'h55, 3'd1);

    // Backpressure: nothing moves and no channel sees ready.
    applyStimulus(4'b1111, 32'h33662211, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_in_ready", {28'd0, rr_in_ready}, 32'h0);
      tick();
      checkRr("bp_hold", 1'b1, 8'h55, 3'd1);
    end
    applyStimulus(4'b1111, 32'h33662211, 1'b1);
    checkOutput("bp_release_ready", {28'd0, rr_in_ready}, 32'h4);
    tick(); checkRr("bp_release", 1'b1, 8'h66, 3'd2);

    // Drain: one word from channel 3, then no requests.
    applyStimulus(4'b1000, 32'h3C000000, 1'b1);
    checkOutput("drain_ready", {28'd0, rr_in_ready}, 32'h8);
    tick(); checkRr("drain_word", 1'b1, 8'h3C, 3'd3);
    applyStimulus(4'b0000, 32'h3C000000, 1'b1);
    tick(); checkRr("drain_empty", 1'b0, 8'h3C, 3'd3);
    tick(); checkOutput("drain_stays_empty", {31'd0, rr_out_valid}, 32'h0);
    applyStimulus(4'b1111, 32'hB3B2B1B0, 1'b1);
    checkOutput("after_drain_ready", {28'd0, rr_in_ready}, 32'h1);
    tick(); checkRr("after_drain", 1'b1, 8'hB0, 3'd0);

`ifdef CHAN_MUX_FORCE_SEL_EN
    // Forced select: only channel 2 is accepted, then index 5 grants nothing.
    rr_force_en  = 1'b1;
    rr_force_sel = 3'd2;
    #1;
    checkOutput("force2_ready", {28'd0, rr_in_ready}, 32'h4);
    tick(); checkRr("force2_a", 1'b1, 8'hB2, 3'd2);
    checkOutput("force2_ready_again", {28'd0, rr_in_ready}, 32'h4);
    tick(); checkRr("force2_b", 1'b1, 8'hB2, 3'd2);
    rr_force_sel = 3'd5;
    #1;
    checkOutput("force5_ready", {28'd0, rr_in_ready}, 32'h0);
    tick(); checkOutput("force5_valid", {31'd0, rr_out_valid}, 32'h0);
    rr_force_en = 1'b0;
    #1;
    checkOutput("unforced_ready", {28'd0, rr_in_ready}, 32'h8);
`endif

    // Fixed priority: channel 1 beats channel 2 every cycle.
    fp_in_data  = 32'h00221100;
    fp_in_valid = 4'b0110;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("fp_ready_ch1", {28'd0, fp_in_ready}, 32'h2);
      tick();
      checkOutput("fp_ch1", {30'd0, fp_out_ch}, 32'h1);
      checkOutput("fp_data1", {24'd0, fp_out_data}, 32'h11);
    end
    fp_in_valid = 4'b0100;
    #1;
    checkOutput("fp_ready_ch2", {28'd0, fp_in_ready}, 32'h4);
    tick();
    checkOutput("fp_ch2", {30'd0, fp_out_ch}, 32'h2);
    checkOutput("fp_data2", {24'd0, fp_out_data}, 32'h22);
    checkOutput("fp_valid2", {31'd0, fp_out_valid}, 32'h1);

    // Reset while holding a word throws it away.
    reset_n = 1'b0;
    tick();
    checkOutput("midreset_fp_valid", {31'd0, fp_out_valid}, 32'h0);
    checkOutput("midreset_fp_data", {24'd0, fp_out_data}, 32'h0);
    checkRr("midreset_rr", 1'b0, 8'h00, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_mux_rr.md
Name: chan_mux_rr

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with per-channel valid/ready handshake.
- Arbitrates among requesting channels by fixed priority or round-robin, and drives one output register stage.
- Sits between datapath producers (register file ports, ALU result sources) and a single shared consumer.
- Successor to the combinational 4:1 select mux: the external select is replaced by internal arbitration.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- SEL_W, 2, channel index width; 2**SEL_W >= NUM_CH required.
- MODE, 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel request.
- in_ready  output  NUM_CH  per-channel accept; combinational.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer accept.
- out_ch  output  SEL_W  registered index of the channel held in out_data.

Behaviour:
- Reset (reset_n=0 at a rising clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last_ptr=NUM_CH-1, so channel 0 has first priority.
  - in_ready is all zero while reset_n=0.
  - Reset mid-transfer discards the held word without handshake.
- load = !out_valid || out_ready (combinational).
- Grant (combinational, one-hot or zero):
  - MODE=0: lowest index i with in_valid[i]=1.
  - MODE=1: first i with in_valid[i]=1, scanning from (last_ptr+1) mod NUM_CH upward with wrap-around.
- in_ready[i] = load && grant[i] && reset_n. At most one bit is set per cycle.
- Transfer in: in_valid[i] && in_ready[i] at a rising edge.
  - out_data <= channel i data; out_ch <= i; out_valid <= 1.
  - MODE=1 only: last_ptr <= i.
- Transfer out: out_valid && out_ready at a rising edge.
  - If no transfer in occurs the same edge, out_valid <= 0. out_data and out_ch hold their old values.
- Simultaneous out and in on the same edge: the new word replaces the old one and out_valid stays 1. Full throughput is 1 word/cycle.
- Backpressure: out_valid=1 and out_ready=0 gives load=0, so all in_ready=0. out_data, out_ch and last_ptr are held stable.
- Latency: 1 cycle from accept on the input to out_valid.
- No request (in_valid=0): no grant, and last_ptr is unchanged.
- Round-robin wraps from index NUM_CH-1 to 0.
- Channels with index >= NUM_CH do not exist. out_ch never exceeds NUM_CH-1.
- Data is passed through unmodified; no width conversion.

Optional Feature:
- Macro: CHAN_MUX_FORCE_SEL_EN.
- Defined:
  - Adds ports force_en (input, 1) and force_sel (input, SEL_W).
  - When force_en=1, only channel force_sel is eligible for grant, whatever MODE is.
  - force_sel >= NUM_CH means no grant.
  - In MODE=1, last_ptr still updates to the accepted index.
  - force_en=0 gives normal arbitration.
- Not defined: the ports are absent and arbitration is as above.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x00, out_ch=0 throughout.
- Round-robin fairness (MODE=1): all four channels valid with data 0xA0,0xA1,0xA2,0xA3; out_ready=1 -> out_ch sequence 0,1,2,3,0 and out_data 0xA0..0xA3,0xA0 on consecutive cycles, out_valid=1 every cycle after the first.
- Fixed priority (MODE=0): in_valid=0110 -> ch1 is always granted and in_ready[2] never goes to 1. Drop in_valid[1] -> ch2 is granted the next cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=0x55 -> out_data, out_ch stable; in_ready=0000. Raise out_ready -> the next word is accepted the same edge and out_valid stays 1.
- Drain: single request ch3 with data 0x3C, then in_valid=0 -> out_valid=1 for exactly one cycle with out_ready=1, then 0. The next round-robin grant starts at ch0.
- CHAN_MUX_FORCE_SEL_EN defined: force_en=1, force_sel=2, all valid -> only ch2 is accepted. force_sel=5 with NUM_CH=4 -> no grant, out_valid falls to 0 after drain.
